beta_dmem_responder: RTL

- Data-memory responder: the memory-side end of the LSU read/write port protocol (req -> ready -> one-cycle valid).
- Holds a word-organised SRAM model with byte strobes and independent read and write FSMs.
- Programmable response latency per port.
- Used as the core's tightly coupled data memory and as the LSU's reference responder in simulation.

---
 rtl/beta_dmem_responder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/beta_dmem_responder.sv
// Data-memory responder: word-organised SRAM model behind independent read and write
// req/ready/valid ports, each with its own fixed response latency.
module beta_dmem_responder #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned MemDepth     = 1024,
  parameter logic [AddressWidth-1:0] BaseAddr = '0,
  parameter int unsigned ReadLatency  = 1,
  parameter int unsigned WriteLatency = 1
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    dmem_rdata_req_i,
  input  logic [AddressWidth-1:0] dmem_rdata_addr_i,
  input  logic [DataWidth/8-1:0]  dmem_rdata_strb_i,
  output logic                    dmem_rdata_ready_o,
  output logic                    dmem_rdata_valid_o,
  output logic [DataWidth-1:0]    dmem_rdata_data_o,
  output logic                    dmem_rdata_err_o,
  input  logic                    dmem_wdata_req_i,
  input  logic [AddressWidth-1:0] dmem_wdata_addr_i,
  input  logic [DataWidth/8-1:0]  dmem_wdata_strb_i,
  input  logic [DataWidth-1:0]    dmem_wdata_data_i,
  output logic                    dmem_wdata_ready_o,
  output logic                    dmem_wdata_valid_o,
  output logic                    dmem_wdata_err_o
);

  localparam int unsigned StrbW = DataWidth / 8;
  localparam int unsigned IdxW  = (MemDepth > 1) ? $clog2(MemDepth) : 1;
  localparam int unsigned WordW = AddressWidth - 2;
  localparam logic [WordW-1:0] DepthWords = WordW'(MemDepth);
  localparam logic [3:0] RdLoad = 4'(ReadLatency - 1);
  localparam logic [3:0] WrLoad = 4'(WriteLatency - 1);

  typedef enum logic [1:0] {StIdle, StAck, StWait, StResp} state_e;

  logic [DataWidth-1:0] mem [MemDepth];

  state_e                  r_state_q, w_state_q;
  logic [AddressWidth-1:0] r_addr_q, w_addr_q;
  logic [StrbW-1:0]        r_strb_q, w_strb_q;
  logic [DataWidth-1:0]    w_data_q;
  logic [3:0]              r_cnt_q, w_cnt_q;

  // Address decode and lane alignment for both ports, from the latched request
  logic [AddressWidth-1:0] r_off, w_off;
  logic                    r_hit, w_hit;
  logic [IdxW-1:0]         r_idx, w_idx;
  logic [1:0]              r_lane, w_lane;
  logic [StrbW-1:0]        r_estrb, w_estrb;
  logic [DataWidth-1:0]    r_mask, w_data_sh, r_word, r_data_next;

  always_comb begin
    r_off     = r_addr_q - BaseAddr;
    w_off     = w_addr_q - BaseAddr;
    r_hit     = (r_addr_q >= BaseAddr) && (r_off[AddressWidth-1:2] < DepthWords);
    w_hit     = (w_addr_q >= BaseAddr) && (w_off[AddressWidth-1:2] < DepthWords);
    r_idx     = r_off[IdxW+1:2];
    w_idx     = w_off[IdxW+1:2];
    r_lane    = r_off[1:0];
    w_lane    = w_off[1:0];
    r_estrb   = r_strb_q << r_lane;
    w_estrb   = w_strb_q << w_lane;
    w_data_sh = w_data_q << {w_lane, 3'b000};
    r_word    = mem[r_idx];
    r_mask    = '0;
    for (int i = 0; i < StrbW; i++) begin
      r_mask[8*i +: 8] = {8{r_estrb[i]}};
      // A write committing on the same edge the read samples must be visible to it
      if (w_state_q == StResp && w_hit && w_idx == r_idx && w_estrb[i]) begin
        r_word[8*i +: 8] = w_data_sh[8*i +: 8];
      end
    end
    r_data_next = r_hit ? ((r_word & r_mask) >> {r_lane, 3'b000}) : '0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state_q          <= StIdle;
      r_addr_q           <= '0;
      r_strb_q           <= '0;
      r_cnt_q            <= '0;
      dmem_rdata_ready_o <= 1'b0;
      dmem_rdata_valid_o <= 1'b0;
      dmem_rdata_err_o   <= 1'b0;
      dmem_rdata_data_o  <= '0;
    end else begin
      unique case (r_state_q)
        StIdle: begin
          if (dmem_rdata_req_i) begin
            r_addr_q           <= dmem_rdata_addr_i;
            r_strb_q           <= dmem_rdata_strb_i;
            dmem_rdata_ready_o <= 1'b1;
            r_state_q          <= StAck;
          end
        end
        StAck: begin
          dmem_rdata_ready_o <= 1'b0;
          r_cnt_q            <= RdLoad;
          if (RdLoad == 4'd0) begin
            dmem_rdata_valid_o <= 1'b1;
            dmem_rdata_err_o   <= ~r_hit;
            dmem_rdata_data_o  <= r_data_next;
            r_state_q          <= StResp;
          end else begin
            r_state_q <= StWait;
          end
        end
        StWait: begin
          r_cnt_q <= r_cnt_q - 4'd1;
          if (r_cnt_q == 4'd1) begin
            dmem_rdata_valid_o <= 1'b1;
            dmem_rdata_err_o   <= ~r_hit;
            dmem_rdata_data_o  <= r_data_next;
            r_state_q          <= StResp;
          end
        end
        StResp: begin
          dmem_rdata_valid_o <= 1'b0;
          dmem_rdata_err_o   <= 1'b0;
          dmem_rdata_data_o  <= '0;
          r_state_q          <= StIdle;
        end
        default: r_state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      w_state_q          <= StIdle;
      w_addr_q           <= '0;
      w_strb_q           <= '0;
      w_data_q           <= '0;
      w_cnt_q            <= '0;
      dmem_wdata_ready_o <= 1'b0;
      dmem_wdata_valid_o <= 1'b0;
      dmem_wdata_err_o   <= 1'b0;
    end else begin
      unique case (w_state_q)
        StIdle: begin
          if (dmem_wdata_req_i) begin
            w_addr_q           <= dmem_wdata_addr_i;
            w_strb_q           <= dmem_wdata_strb_i;
            w_data_q           <= dmem_wdata_data_i;
            dmem_wdata_ready_o <= 1'b1;
            w_state_q          <= StAck;
          end
        end
        StAck: begin
          dmem_wdata_ready_o <= 1'b0;
          w_cnt_q            <= WrLoad;
          if (WrLoad == 4'd0) begin
            dmem_wdata_valid_o <= 1'b1;
            dmem_wdata_err_o   <= ~w_hit;
            w_state_q          <= StResp;
          end else begin
            w_state_q <= StWait;
          end
        end
        StWait: begin
          w_cnt_q <= w_cnt_q - 4'd1;
          if (w_cnt_q == 4'd1) begin
            dmem_wdata_valid_o <= 1'b1;
            dmem_wdata_err_o   <= ~w_hit;
            w_state_q          <= StResp;
          end
        end
        StResp: begin
          dmem_wdata_valid_o <= 1'b0;
          dmem_wdata_err_o   <= 1'b0;
          w_state_q          <= StIdle;
        end
        default: w_state_q <= StIdle;
      endcase
    end
  end

  // Commit at the end of the write's RESP cycle; reset forces IDLE so aborted writes never land
  always_ff @(posedge clk_i) begin
    if (w_state_q == StResp && w_hit) begin
      for (int i = 0; i < StrbW; i++) begin
        if (w_estrb[i]) mem[w_idx][8*i +: 8] <= w_data_sh[8*i +: 8];
      end
    end
  end

endmodule
